// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide arbiter.
//   md_op_e           : operator encoding understood by the multdiv unit
//   md_arb_state_e    : arbiter FSM state
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } md_arb_state_e;

endpackage

// File: rtl/ibex_multdiv_arb_pick.sv
// Two-way request picker.
//   req_i  : request bits, [0]=port0, [1]=port1
//   prio_i : index of the port that wins when both request
//   gnt_o  : one-hot winner (zero when nothing requests)
module ibex_multdiv_arb_pick (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] |  prio_i);

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multdiv unit between two requesters.
// A request is granted combinationally in IDLE; the winner's operation is
// captured and presented to the unit while BUSY, and the result is routed
// back to the owner until it accepts it.
// Ports:
//   clk_i, rst_ni                  : clock, synchronous active-low reset
//   req_i/is_div_i/operator_i/
//   signed_mode_i/op_a_i/op_b_i    : per-requester operation
//   gnt_o, rvalid_o, rready_i      : per-requester handshakes
//   result_o                       : shared result bus
//   md_*_o / md_result_i/md_valid_i: multdiv unit side
//   data_ind_timing_o              : DataIndTiming constant
// Build option: define IBEX_MULTDIV_ARB_RR_EN for round-robin tie breaking;
// otherwise port0 has fixed priority.
module ibex_multdiv_arbiter
  import ibex_pkg::*;
#(
  parameter bit DataIndTiming = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_i,
  input  logic [1:0]      is_div_i,
  input  logic [1:0][1:0] operator_i,
  input  logic [1:0][1:0] signed_mode_i,
  input  logic [1:0][31:0] op_a_i,
  input  logic [1:0][31:0] op_b_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rvalid_o,
  input  logic [1:0]      rready_i,
  output logic [31:0]     result_o,
  output logic            md_mult_en_o,
  output logic            md_div_en_o,
  output logic            md_mult_sel_o,
  output logic            md_div_sel_o,
  output logic [1:0]      md_operator_o,
  output logic [1:0]      md_signed_mode_o,
  output logic [31:0]     md_op_a_o,
  output logic [31:0]     md_op_b_o,
  output logic            md_ready_o,
  input  logic [31:0]     md_result_i,
  input  logic            md_valid_i,
  output logic            data_ind_timing_o
);

  md_arb_state_e state_q, state_d;
  logic          owner_q, owner_d;
  logic          is_div_q, is_div_d;
  md_op_e        operator_q, operator_d;
  logic [1:0]    signed_mode_q, signed_mode_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;

  logic          prio;
  logic [1:0]    pick_gnt;
  logic          win;
  logic          busy;
  logic          complete;

`ifdef IBEX_MULTDIV_ARB_RR_EN
  // Holds the port that wins the next tie, i.e. the one not granted last.
  logic prio_q, prio_d;
  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  ibex_multdiv_arb_pick u_pick (
    .req_i  (req_i),
    .prio_i (prio),
    .gnt_o  (pick_gnt)
  );

  assign win      = pick_gnt[1];
  assign busy     = (state_q == ARB_BUSY);
  assign complete = busy & md_valid_i & rready_i[owner_q];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    is_div_d      = is_div_q;
    operator_d    = operator_q;
    signed_mode_d = signed_mode_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
`ifdef IBEX_MULTDIV_ARB_RR_EN
    prio_d        = prio_q;
`endif
    gnt_o         = 2'b00;

    case (state_q)
      ARB_IDLE: begin
        // A grant during reset would be lost, so it is suppressed.
        if (rst_ni && (pick_gnt != 2'b00)) begin
          gnt_o         = pick_gnt;
          owner_d       = win;
          is_div_d      = is_div_i[win];
          operator_d    = md_op_e'(operator_i[win]);
          signed_mode_d = signed_mode_i[win];
          op_a_d        = op_a_i[win];
          op_b_d        = op_b_i[win];
`ifdef IBEX_MULTDIV_ARB_RR_EN
          prio_d        = ~win;
`endif
          state_d       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (complete) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ARB_IDLE;
      owner_q       <= 1'b0;
      is_div_q      <= 1'b0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= 2'b00;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
`ifdef IBEX_MULTDIV_ARB_RR_EN
      prio_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      is_div_q      <= is_div_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
`ifdef IBEX_MULTDIV_ARB_RR_EN
      prio_q        <= prio_d;
`endif
    end
  end

  // Unit side is quiet in IDLE so a stray md_valid_i cannot reach anyone.
  assign md_mult_en_o     = busy & ~is_div_q;
  assign md_mult_sel_o    = busy & ~is_div_q;
  assign md_div_en_o      = busy &  is_div_q;
  assign md_div_sel_o     = busy &  is_div_q;
  assign md_operator_o    = busy ? operator_q    : 2'b00;
  assign md_signed_mode_o = busy ? signed_mode_q : 2'b00;
  assign md_op_a_o        = busy ? op_a_q        : 32'd0;
  assign md_op_b_o        = busy ? op_b_q        : 32'd0;
  assign md_ready_o       = busy & rready_i[owner_q];

  assign rvalid_o[0]      = busy & md_valid_i & ~owner_q;
  assign rvalid_o[1]      = busy & md_valid_i &  owner_q;
  assign result_o         = busy ? md_result_i : 32'd0;

  assign data_ind_timing_o = DataIndTiming;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
module tb_ibex_multdiv_arbiter;
  import ibex_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_i, is_div_i, rready_i;
  logic [1:0][1:0]  operator_i, signed_mode_i;
  logic [1:0][31:0] op_a_i, op_b_i;
  logic [1:0]       gnt_o, rvalid_o;
  logic [31:0]      result_o, md_op_a_o, md_op_b_o, md_result_i;
  logic             md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  logic [1:0]       md_operator_o, md_signed_mode_o;
  logic             md_ready_o, md_valid_i, data_ind_timing_o;

  always #5 clk_i = ~clk_i;

  ibex_multdiv_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .is_div_i(is_div_i),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .result_o(result_o),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o), .md_ready_o(md_ready_o),
    .md_result_i(md_result_i), .md_valid_i(md_valid_i),
    .data_ind_timing_o(data_ind_timing_o)
  );

  // Behavioural multdiv unit: 3 enabled cycles for multiply, 5 for divide,
  // then holds its result until md_ready_o.
  logic        u_valid, inj_valid;
  logic [2:0]  u_cnt;
  logic [31:0] u_res;

  function automatic logic [31:0] unit_calc(logic [1:0] op, logic [1:0] sm,
                                            logic [31:0] a, logic [31:0] b);
    logic signed [33:0] sa, sb;
    logic signed [67:0] p;
    logic signed [31:0] ia, ib;
    sa = sm[0] ? {{2{a[31]}}, a} : {2'b00, a};
    sb = sm[1] ? {{2{b[31]}}, b} : {2'b00, b};
    p  = sa * sb;
    ia = a;
    ib = b;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm == 2'b11) return ia / ib;
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm == 2'b11) return ia % ib;
        return a % b;
      end
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      u_valid <= 1'b0;
      u_cnt   <= 3'd0;
    end else if (u_valid) begin
      if (md_ready_o) begin
        u_valid <= 1'b0;
        u_cnt   <= 3'd0;
      end
    end else if (md_mult_en_o || md_div_en_o) begin
      if (u_cnt == (md_div_en_o ? 3'd4 : 3'd2)) begin
        u_valid <= 1'b1;
        u_res   <= unit_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
      end else begin
        u_cnt <= u_cnt + 3'd1;
      end
    end
  end

  assign md_valid_i  = u_valid | inj_valid;
  assign md_result_i = u_valid ? u_res : 32'h1234_5678;

  typedef struct {
    logic        owner;
    logic [31:0] res;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(logic owner, logic [31:0] res);
    exp_t e;
    e.owner = owner;
    e.res   = res;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every accepted result is compared against the queue head.
  always @(negedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (rvalid_o[i] && rready_i[i]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_result: port %0d observed %h expected none", i, result_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          assert ({1'(i), result_o} === {e.owner, e.res}) else begin
            errors++;
            $error("FAIL result: observed port %0d %h expected port %0d %h",
                   i, result_o, e.owner, e.res);
          end
        end
      end
    end
  end

  task automatic set_port(int p, logic div, logic [1:0] op, logic [1:0] sm,
                          logic [31:0] a, logic [31:0] b);
    is_div_i[p]      = div;
    operator_i[p]    = op;
    signed_mode_i[p] = sm;
    op_a_i[p]        = a;
    op_b_i[p]        = b;
  endtask

  // Returns #1 after the first edge that leaves the unit disabled.
  task automatic wait_done(string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk_i); #1;
      if (!(md_mult_en_o || md_div_en_o)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout_%s: observed busy expected idle", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_ni = 1'b0; req_i = '0; is_div_i = '0; operator_i = '0;
    signed_mode_i = '0; op_a_i = '0; op_b_i = '0; rready_i = 2'b11;
    inj_valid = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_en", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o}, 0);
    chk("rst_ops", md_op_a_o | md_op_b_o, 0);
    chk("rst_ready", md_ready_o, 0);
    chk("data_ind_timing", data_ind_timing_o, 0);
    rst_ni = 1'b1;

    // Single multiply on port0
    set_port(0, 1'b0, MD_OP_MULL, 2'b00, 32'd3, 32'd5);
    req_i = 2'b01;
    #1;
    chk("mull_gnt", gnt_o, 2'b01);
    chk("mull_en_idle", md_mult_en_o, 0);
    push(1'b0, 32'd15);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    chk("mull_en", {md_mult_en_o, md_mult_sel_o, md_div_en_o}, 3'b110);
    chk("mull_op_a", md_op_a_o, 32'd3);
    chk("mull_op_b", md_op_b_o, 32'd5);
    chk("mull_gnt_busy", gnt_o, 0);
    wait_done("mull");

    // Simultaneous requests from a freshly reset arbiter
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    set_port(0, 1'b1, MD_OP_DIV, 2'b00, 32'd100, 32'd7);
    set_port(1, 1'b1, MD_OP_REM, 2'b00, 32'd100, 32'd7);
    req_i = 2'b11;
    #1;
    chk("both_gnt0", gnt_o, 2'b01);
    push(1'b0, 32'd14);
    @(posedge clk_i); #1;
    chk("both_gnt_busy", gnt_o, 0);
    chk("both_div_en", {md_div_en_o, md_div_sel_o, md_mult_en_o}, 3'b110);
    chk("both_op_b", md_op_b_o, 32'd7);
    wait_done("div0");
`ifdef IBEX_MULTDIV_ARB_RR_EN
    chk("both_gnt_rr", gnt_o, 2'b10);
    push(1'b1, 32'd2);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    wait_done("rem1");
`else
    chk("both_gnt_fixed", gnt_o, 2'b01);
    push(1'b0, 32'd14);
    @(posedge clk_i); #1;
    req_i = 2'b10;
    wait_done("div0b");
    chk("both_gnt_p1", gnt_o, 2'b10);
    push(1'b1, 32'd2);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    wait_done("rem1");
`endif

    // Divide / remainder by zero on port1
    set_port(1, 1'b1, MD_OP_DIV, 2'b11, 32'hFFFF_FFF8, 32'd0);
    req_i = 2'b10;
    #1;
    chk("divz_gnt", gnt_o, 2'b10);
    push(1'b1, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    chk("divz_sm", md_signed_mode_o, 2'b11);
    wait_done("divz");
    set_port(1, 1'b1, MD_OP_REM, 2'b00, 32'd9, 32'd0);
    req_i = 2'b10;
    #1;
    chk("remz_gnt", gnt_o, 2'b10);
    push(1'b1, 32'd9);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    chk("remz_operator", md_operator_o, 2'd3);
    wait_done("remz");

    // Backpressure from port0 while port1 waits
    set_port(0, 1'b0, MD_OP_MULL, 2'b00, 32'd6, 32'd7);
    rready_i = 2'b10;
    req_i = 2'b01;
    #1;
    push(1'b0, 32'd42);
    @(posedge clk_i); #1;
    set_port(1, 1'b0, MD_OP_MULL, 2'b00, 32'd2, 32'd3);
    req_i = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (rvalid_o == 2'b01) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    chk("bp_rvalid_seen", {31'd0, seen}, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", rvalid_o, 2'b01);
      chk("bp_result", result_o, 32'd42);
      chk("bp_ready", md_ready_o, 0);
      chk("bp_gnt", gnt_o, 0);
      chk("bp_en", md_mult_en_o, 1);
      @(posedge clk_i); #1;
    end
    rready_i = 2'b11;
    #1;
    chk("bp_ready_up", md_ready_o, 1);
    chk("bp_gnt_same_cycle", gnt_o, 0);
    push(1'b1, 32'd6);
    @(posedge clk_i); #1;
    chk("bp_gnt_bubble", gnt_o, 2'b10);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    wait_done("bp_p1");

    // Reset in the middle of a divide
    set_port(0, 1'b1, MD_OP_DIV, 2'b00, 32'd50, 32'd5);
    req_i = 2'b01;
    @(posedge clk_i); #1;
    req_i = 2'b00;
    @(posedge clk_i); #1;
    chk("mid_div_en", md_div_en_o, 1);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("mid_rst_en", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o}, 0);
    chk("mid_rst_rvalid", rvalid_o, 0);
    chk("mid_rst_result", result_o, 0);
    rst_ni = 1'b1;
    inj_valid = 1'b1;
    #1;
    chk("idle_valid_rvalid", rvalid_o, 0);
    chk("idle_valid_result", result_o, 0);
    chk("idle_valid_ready", md_ready_o, 0);
    inj_valid = 1'b0;
    set_port(0, 1'b0, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2);
    req_i = 2'b01;
    #1;
    chk("mulh_gnt", gnt_o, 2'b01);
    push(1'b0, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    wait_done("mulh");

    @(posedge clk_i); #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
